// File: rtl/turn_signal_conditioner.sv
// Turn-signal front end: synchronises and debounces the lever/hazard switches,
// resolves them into left/right requests and paces updates on a periodic step strobe.
module turn_signal_conditioner #(
   parameter int DEB_CYCLES = 16,
   parameter int TICK_DIV   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_left,
   input  logic sw_right,
   input  logic sw_hazard,
   output logic a,
   output logic b,
   output logic step_en
);

   localparam int DW = $clog2(DEB_CYCLES);
   localparam int TW = $clog2(TICK_DIV);

   logic [2:0] raw;
   logic [2:0] deb;
   logic       a_next;
   logic       b_next;
   logic [TW-1:0] tick_reg;
   logic       wrap;

   // Channel order: 0 = left, 1 = right, 2 = hazard
   assign raw = {sw_hazard, sw_right, sw_left};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
         logic          s1_reg;
         logic          s2_reg;
         logic          deb_reg;
         logic [DW-1:0] cnt_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s1_reg  <= 1'b0;
               s2_reg  <= 1'b0;
               deb_reg <= 1'b0;
               cnt_reg <= '0;
            end else begin
               s1_reg <= raw[gi];
               s2_reg <= s1_reg;
               if (s2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DW'(DEB_CYCLES - 1)) begin
                  deb_reg <= s2_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign deb[gi] = deb_reg;
      end
   endgenerate

   // Both levers at once is treated as a conflict and shows nothing, never hazard
   always_comb begin
      a_next = 1'b0;
      b_next = 1'b0;
      if (deb[2]) begin
         a_next = 1'b1;
         b_next = 1'b1;
      end else if (deb[0] && !deb[1]) begin
         a_next = 1'b1;
      end else if (deb[1] && !deb[0]) begin
         b_next = 1'b1;
      end
   end

   assign wrap = (tick_reg == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_reg <= '0;
         step_en  <= 1'b0;
         a        <= 1'b0;
         b        <= 1'b0;
      end else begin
         tick_reg <= wrap ? '0 : tick_reg + 1'b1;
         step_en  <= wrap;
         if (wrap) begin
            a <= a_next;
            b <= b_next;
         end
      end
   end

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Randomised bench for turn_signal_conditioner: a reference model queues the request
// expected at every strobe; a monitor pops and compares whenever step_en is seen.
module tb_turn_signal_conditioner;

   localparam int DEB = 16;
   localparam int TD  = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic sw_left = 1'b0;
   logic sw_right = 1'b0;
   logic sw_hazard = 1'b0;
   logic a;
   logic b;
   logic step_en;

   int n_cmp = 0;
   int n_bad = 0;

   turn_signal_conditioner #(.DEB_CYCLES(DEB), .TICK_DIV(TD)) dut (
      .clk(clk),
      .reset(reset),
      .sw_left(sw_left),
      .sw_right(sw_right),
      .sw_hazard(sw_hazard),
      .a(a),
      .b(b),
      .step_en(step_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Request table, returns {a, b}
   function automatic logic [1:0] resolve(input logic [2:0] d);
      if (d[2]) return 2'b11;
      case (d[1:0])
         2'b01:   return 2'b10;
         2'b10:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   // Reference model: raw sample history gives the 2-cycle synchroniser delay,
   // a run length of disagreeing samples decides when a switch change is accepted.
   logic [1:0] exp_q[$];
   logic [2:0] hist[$];
   logic [2:0] m_deb = 3'b000;
   int         run[3];
   int         edge_n = 0;

   always @(posedge clk) begin
      logic [2:0] s2v;
      if (reset) begin
         edge_n = 0;
         hist.delete();
         m_deb = 3'b000;
         for (int c = 0; c < 3; c++) run[c] = 0;
         exp_q.delete();
      end else begin
         edge_n++;
         s2v = (hist.size() >= 2) ? hist[hist.size()-2] : 3'b000;
         if (edge_n % TD == 0) exp_q.push_back(resolve(m_deb));
         for (int c = 0; c < 3; c++) begin
            if (s2v[c] != m_deb[c]) begin
               run[c]++;
               if (run[c] == DEB) begin
                  m_deb[c] = s2v[c];
                  run[c] = 0;
               end
            end else begin
               run[c] = 0;
            end
         end
         hist.push_back({sw_hazard, sw_right, sw_left});
         if (hist.size() > 3) void'(hist.pop_front());
      end
   end

   // Monitor
   logic [1:0] held = 2'b00;
   always @(negedge clk) begin
      logic [1:0] e;
      if (reset) begin
         check("reset_outputs", {a, b, step_en}, 3'b000);
         held = 2'b00;
      end else if (step_en) begin
         if (exp_q.size() == 0) begin
            check("spurious_strobe", {2'b00, step_en}, 3'b000);
         end else begin
            e = exp_q.pop_front();
            check("strobe_ab", {1'b0, a, b}, {1'b0, e});
            held = e;
         end
      end else begin
         check("hold_ab", {1'b0, a, b}, {1'b0, held});
         n_cmp++;
         if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_strobe: step_en=0, expected a strobe at t=%0t", $time);
            exp_q.delete();
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic async_reset_pulse(input int offset);
      @(negedge clk);
      #(offset);
      reset = 1'b1;
      #1;
      check("async_reset", {a, b, step_en}, 3'b000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      cycles(3);
      reset = 1'b0;

      cycles(40);                                // idle, strobes only
      sw_left = 1'b1;                            // clean left
      cycles(60);
      for (int i = 0; i < 10; i++) begin         // bouncing right
         sw_right = ~sw_right;
         cycles(3);
      end
      sw_right = 1'b1;
      cycles(40);                                // lever conflict
      sw_hazard = 1'b1;
      cycles(40);
      sw_hazard = 1'b0;
      sw_right = 1'b0;
      cycles(61);                                // a=1 again, then reset mid-period
      async_reset_pulse(2);
      cycles(40);
      sw_hazard = 1'b1;                          // glitch one short of acceptance
      cycles(DEB - 1);
      sw_hazard = 1'b0;
      cycles(50);

      for (int seg = 0; seg < 300; seg++) begin
         int mode;
         mode = $urandom_range(0, 39);
         if (mode == 0) begin
            async_reset_pulse($urandom_range(1, 4));
         end else if (mode < 12) begin
            int len;
            int ch;
            len = $urandom_range(1, 20);
            ch  = $urandom_range(0, 2);
            for (int k = 0; k < len; k++) begin
               @(negedge clk);
               case (ch)
                  0: sw_left   = $urandom_range(0, 1);
                  1: sw_right  = $urandom_range(0, 1);
                  default: sw_hazard = $urandom_range(0, 1);
               endcase
            end
         end else begin
            @(negedge clk);
            sw_left   = $urandom_range(0, 1);
            sw_right  = $urandom_range(0, 1);
            sw_hazard = ($urandom_range(0, 3) == 0);
            cycles($urandom_range(1, 40));
         end
      end

      cycles(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
